// File: rtl/sub8_diff_accum.sv
// sub8_diff_accum: restores clamped values from wrapped 8-bit differences and accumulates
// fixed-length blocks into a saturating signed sum plus overflow-event count, handed off via valid/ready.
module sub8_diff_accum #(
   parameter int ACC_W     = 16,
   parameter int BLOCK_LEN = 8,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_diff,
   input  logic                    in_ovf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        out_sum,
   output logic [CNT_W-1:0]        out_ovf_cnt,
   output logic                    out_acc_sat
);

   // state | meaning
   // ACCUM | accepting samples into the running block
   // HOLD  | block result presented, waiting for out_ready
   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   localparam int SMP_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(BLOCK_LEN - 1);

   logic [0:0]       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] ovf_cnt;
   logic             sat;
   logic [SMP_W-1:0] smp_cnt;

   logic [ACC_W:0]   samp;
   logic [ACC_W:0]   sum_wide;
   logic             sum_clip;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] ovf_cnt_nxt;
   logic             sat_nxt;
   logic             accept;

   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_HOLD);
   assign accept    = in_valid && (state == ST_ACCUM);

   // An overflowed wrapped difference carries the opposite sign of the true result.
   always_comb begin
      samp = {{(ACC_W-7){in_diff[7]}}, in_diff};
      if (in_ovf) begin
         if (in_diff[7]) samp = {{(ACC_W-7){1'b0}}, 8'h7F};
         else            samp = {{(ACC_W-7){1'b1}}, 8'h80};
      end
   end

   always_comb begin
      sum_wide = {acc[ACC_W-1], acc} + samp;
      sum_clip = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      acc_nxt  = sum_wide[ACC_W-1:0];
      if (sum_clip) acc_nxt = {sum_wide[ACC_W], {(ACC_W-1){~sum_wide[ACC_W]}}};
      sat_nxt     = sat | sum_clip;
      ovf_cnt_nxt = ovf_cnt;
      if (in_ovf && !(&ovf_cnt)) ovf_cnt_nxt = ovf_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_ACCUM;
         acc         <= '0;
         ovf_cnt     <= '0;
         sat         <= 1'b0;
         smp_cnt     <= '0;
         out_sum     <= '0;
         out_ovf_cnt <= '0;
         out_acc_sat <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (accept) begin
                  if (smp_cnt == SMP_LAST) begin
                     out_sum     <= acc_nxt;
                     out_ovf_cnt <= ovf_cnt_nxt;
                     out_acc_sat <= sat_nxt;
                     acc         <= '0;
                     ovf_cnt     <= '0;
                     sat         <= 1'b0;
                     smp_cnt     <= '0;
                     state       <= ST_HOLD;
                  end else begin
                     acc     <= acc_nxt;
                     ovf_cnt <= ovf_cnt_nxt;
                     sat     <= sat_nxt;
                     smp_cnt <= smp_cnt + SMP_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) state <= ST_ACCUM;
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

endmodule

// File: doc/sub8_diff_accum.md
# sub8_diff_accum

Downstream consumer of the 8-bit signed subtractor stage. It takes each wrapped difference and its overflow flag, and first restores the correct clamped value (saturation). It then accumulates a fixed-length block of these clamped differences into a wider signed sum and counts overflow events. Each completed block is presented to the next stage over a valid/ready handshake.

## Interface

Parameters:
- ACC_W, 16: accumulator/output sum width, signed two's complement; ≥ 9.
- BLOCK_LEN, 8: samples per block; ≥ 1.
- CNT_W, 8: overflow-event counter width; ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_diff  input  8  signed wrapped difference from subtractor.
- in_ovf  input  1  subtractor overflow flag for in_diff.
- out_valid  output  1  block result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_W  signed saturated block sum.
- out_ovf_cnt  output  CNT_W  number of in_ovf samples in block, saturating.
- out_acc_sat  output  1  accumulator clamped at least once in block.

## Operation

- Sample clamp (combinational on input):
  - in_ovf=0: s = in_diff (sign-extended to ACC_W+1).
  - in_ovf=1 and in_diff[7]=1: true result was positive, so s = +127.
  - in_ovf=1 and in_diff[7]=0: true result was negative, so s = -128.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid=1.
  - On each accept:
    - acc <= sat_ACC_W(acc + s). The sum is computed in ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. If clamped, the sticky sat flag is set.
    - ovf_cnt increments when in_ovf=1, holding at 2^CNT_W-1 (no wrap).
    - sample count increments.
  - On the accept that makes count == BLOCK_LEN:
    - Load the post-update acc, ovf_cnt and sat into out_sum, out_ovf_cnt, out_acc_sat.
    - Clear the internal acc, ovf_cnt, sat and count.
    - Go to HOLD.
- HOLD:
  - in_ready=0, out_valid=1.
  - Outputs are held stable; in_valid/in_diff/in_ovf are ignored.
  - When out_ready=1: go to ACCUM.
- No sample is dropped or double-counted. A sample is consumed only on a cycle where in_valid and in_ready are both 1.
- BLOCK_LEN=1: every accepted sample produces a result.
- Reset (rst_n=0, any state, any cycle):
  - State goes to ACCUM; the internal acc, ovf_cnt, sat and count are cleared.
  - out_sum=0, out_ovf_cnt=0, out_acc_sat=0, out_valid=0; in_ready=1 once state is ACCUM.
  - A partially accumulated block is discarded.

## Timing

- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready to either.
- Latency: out_valid rises on the cycle after the edge that accepts the BLOCK_LEN-th sample.
- Throughput:
  - One sample per cycle in ACCUM.
  - HOLD lasts at least 1 cycle, then 1 cycle per cycle that out_ready stays low.
  - With out_ready tied high, peak rate is BLOCK_LEN samples per BLOCK_LEN+1 cycles.
- The result handshake completes on the edge where out_valid=1 and out_ready=1. in_ready is 1 on the following cycle.
- out_ready asserted while in ACCUM has no effect.
- Output registers change only on block completion or reset.

## Test plan

- Reset: hold rst_n=0 mid-block after 3 accepts, then release -> out_valid=0, in_ready=1, out_sum=0. Next 8 samples of +1 give out_sum=8, proving the earlier 3 samples were discarded.
- Plain block (defaults): in_diff=1..8, in_ovf=0, back-to-back, out_ready=1 -> out_valid one cycle after the 8th accept; out_sum=36, out_ovf_cnt=0, out_acc_sat=0; in_ready=0 for exactly that cycle.
- Overflow clamp: 4× (in_diff=8'h80, in_ovf=1) then 4× (in_diff=8'h7F, in_ovf=1) -> 4·127 + 4·(-128), giving out_sum=-4 and out_ovf_cnt=8.
- Accumulator saturation (ACC_W=10): 8× (in_diff=8'h7F, in_ovf=0) -> out_sum=511, out_acc_sat=1. Then 8× (in_diff=8'h80, in_ovf=0) -> out_sum=-512, out_acc_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after block completion while driving in_valid=1 -> in_ready=0 throughout, outputs unchanged and no samples consumed. After the handshake, the next block sums only samples accepted after it.
- Counter saturation (CNT_W=2, BLOCK_LEN=6): 6 samples with in_ovf=1 -> out_ovf_cnt=3.
